// File: rtl/event_status_pkg.sv
// ---------------------------------------------------------------------------
// event_status_pkg
//   Shared definitions for the event status bank: the register-map layout
//   (region bases as functions of the channel count), the address-width helper
//   and a small address decoder that splits a word address into a region and
//   a channel index.
//
//   Register map for NUM_CH channels:
//     StatusBase   .. +NUM_CH-1    Status[c]   (read-clear)
//     intEnBase    .. +NUM_CH-1    IntEn[c]    (read/write)
//     overflowAddr                 Overflow    (read-clear, NUM_CH LSBs)
//     countBase    .. +NUM_CH-1    Count[c]    (read-clear, optional)
// ---------------------------------------------------------------------------
package event_status_pkg;

  typedef enum logic [2:0] {
    REGION_STATUS,
    REGION_INTEN,
    REGION_OVERFLOW,
    REGION_COUNT,
    REGION_NONE
  } regionE;

  localparam int StatusBase = 0;

  function automatic int intEnBase(input int numCh);
    return numCh;
  endfunction

  function automatic int overflowAddr(input int numCh);
    return 2 * numCh;
  endfunction

  function automatic int countBase(input int numCh);
    return 2 * numCh + 1;
  endfunction

  // The counter window is always part of the address space, so the address
  // width does not depend on whether the counters are built.
  function automatic int addrWidth(input int numCh);
    return $clog2(3 * numCh + 1);
  endfunction

  function automatic regionE addrRegion(input int addr, input int numCh);
    if (addr < intEnBase(numCh))            return REGION_STATUS;
    if (addr < overflowAddr(numCh))         return REGION_INTEN;
    if (addr == overflowAddr(numCh))        return REGION_OVERFLOW;
    if (addr < countBase(numCh) + numCh)    return REGION_COUNT;
    return REGION_NONE;
  endfunction

  // Channel index inside the addressed region; 0 for single-register regions.
  function automatic int addrChannel(input int addr, input int numCh);
    case (addrRegion(addr, numCh))
      REGION_STATUS: return addr - StatusBase;
      REGION_INTEN:  return addr - intEnBase(numCh);
      REGION_COUNT:  return addr - countBase(numCh);
      default:       return 0;
    endcase
  endfunction

endpackage

// File: rtl/event_status_channel.sv
// ---------------------------------------------------------------------------
// event_status_channel
//   One status channel: the status register with set/clear-on-read logic,
//   lost-event (overflow) detection, the interrupt term, and, when the
//   EVENT_STATUS_COUNTER_EN macro is defined, a saturating event counter.
//
//   Ports:
//     Clock, Reset   system clock (rising edge), async active-high reset
//     ioEvent        set pulses for this channel
//     rdClr          this channel's status register is being read
//     intEn          interrupt enable mask for this channel
//     cntClr         this channel's counter is being read   (counter build)
//     count          saturating event count                 (counter build)
//     status         current status register
//     overflowHit    an event hit a bit that is still pending (combinational)
//     irqTerm        |(status & intEn) (combinational)
// ---------------------------------------------------------------------------
module event_status_channel #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_MASK  = '1
`ifdef EVENT_STATUS_COUNTER_EN
  ,
  parameter int                    CNT_WIDTH   = 16
`endif
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] ioEvent,
  input  logic                  rdClr,
  input  logic [DATA_WIDTH-1:0] intEn,
`ifdef EVENT_STATUS_COUNTER_EN
  input  logic                  cntClr,
  output logic [CNT_WIDTH-1:0]  count,
`endif
  output logic [DATA_WIDTH-1:0] status,
  output logic                  overflowHit,
  output logic                  irqTerm
);

  logic [DATA_WIDTH-1:0] clrMask;

  assign clrMask     = rdClr ? CLEAR_MASK : '0;
  // Bits being cleared by this cycle's read are no longer pending, so an
  // event landing on them is not a lost event.
  assign overflowHit = |(ioEvent & status & ~clrMask);
  assign irqTerm     = |(status & intEn);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  // Set wins over clear: OR-ing the event in last keeps it alive.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) status <= RESET_VALUE;
    else       status <= (status & ~clrMask) | ioEvent;
  end

`ifdef EVENT_STATUS_COUNTER_EN
  localparam logic [CNT_WIDTH-1:0] CountMax = '1;

  logic eventSeen;
  assign eventSeen = |ioEvent;

  // A read restarts the count; an event in the read cycle counts as the
  // first event of the new window.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                               count <= '0;
    else if (cntClr)                         count <= CNT_WIDTH'(eventSeen);
    else if (eventSeen && count != CountMax) count <= count + CNT_WIDTH'(1);
  end
`endif

endmodule

// File: rtl/event_status_bank.sv
// ---------------------------------------------------------------------------
// event_status_bank
//   NUM_CH read-clear status registers set by I/O event pulses, with
//   per-channel interrupt enables, a lost-event overflow summary, a
//   registered interrupt request and registered one-cycle-latency reads.
//
//   Optional: define EVENT_STATUS_COUNTER_EN to add per-channel saturating
//   event counters (CNT_WIDTH bits) at 2*NUM_CH+1 .. 3*NUM_CH. Without it
//   those addresses read 0.
//
//   Ports:
//     Clock, Reset   system clock (rising edge), async active-high reset
//     Sys_RdEn       read strobe, one cycle per access
//     Sys_WrEn       write strobe
//     Sys_Addr       word address
//     Sys_WrData     write data
//     Sys_RdData     registered read data (pre-clear value)
//     Sys_RdValid    high the cycle after an accepted read
//     IO_Event       set pulses, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//     Irq            registered OR of enabled pending status bits
// ---------------------------------------------------------------------------
module event_status_bank
  import event_status_pkg::*;
#(
  parameter int                    NUM_CH      = 4,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_MASK  = '1,
  parameter int                    CNT_WIDTH   = 16,
  localparam int                   ADDR_WIDTH  = addrWidth(NUM_CH)
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Sys_RdEn,
  input  logic                         Sys_WrEn,
  input  logic [ADDR_WIDTH-1:0]        Sys_Addr,
  input  logic [DATA_WIDTH-1:0]        Sys_WrData,
  output logic [DATA_WIDTH-1:0]        Sys_RdData,
  output logic                         Sys_RdValid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] IO_Event,
  output logic                         Irq
);

  logic [DATA_WIDTH-1:0] intEn    [NUM_CH];
  logic [DATA_WIDTH-1:0] chStatus [NUM_CH];
  logic [NUM_CH-1:0]     overflow;
  logic [NUM_CH-1:0]     ovHit;
  logic [NUM_CH-1:0]     irqTerm;
  logic [NUM_CH-1:0]     rdClr;
  logic [NUM_CH-1:0]     wrIntEn;
  logic                  rdOverflow;
  logic [DATA_WIDTH-1:0] rdMux;
  regionE                region;
  int                    chSel;
`ifdef EVENT_STATUS_COUNTER_EN
  logic [CNT_WIDTH-1:0]  chCount [NUM_CH];
  logic [NUM_CH-1:0]     cntClr;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : gChannel
    event_status_channel #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE),
      .CLEAR_MASK  (CLEAR_MASK)
`ifdef EVENT_STATUS_COUNTER_EN
      ,
      .CNT_WIDTH   (CNT_WIDTH)
`endif
    ) uChannel (
      .Clock       (Clock),
      .Reset       (Reset),
      .ioEvent     (IO_Event[c*DATA_WIDTH +: DATA_WIDTH]),
      .rdClr       (rdClr[c]),
      .intEn       (intEn[c]),
`ifdef EVENT_STATUS_COUNTER_EN
      .cntClr      (cntClr[c]),
      .count       (chCount[c]),
`endif
      .status      (chStatus[c]),
      .overflowHit (ovHit[c]),
      .irqTerm     (irqTerm[c])
    );
  end

  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    region     = addrRegion(int'(Sys_Addr), NUM_CH);
    chSel      = addrChannel(int'(Sys_Addr), NUM_CH);
    rdClr      = '0;
    wrIntEn    = '0;
    rdOverflow = 1'b0;
    rdMux      = '0;
`ifdef EVENT_STATUS_COUNTER_EN
    cntClr     = '0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      if (chSel == c) begin
        rdClr[c]   = Sys_RdEn && (region == REGION_STATUS);
        wrIntEn[c] = Sys_WrEn && (region == REGION_INTEN);
`ifdef EVENT_STATUS_COUNTER_EN
        cntClr[c]  = Sys_RdEn && (region == REGION_COUNT);
`endif
        case (region)
          REGION_STATUS: rdMux = chStatus[c];
          REGION_INTEN:  rdMux = intEn[c];
`ifdef EVENT_STATUS_COUNTER_EN
          REGION_COUNT:  rdMux[CNT_WIDTH-1:0] = chCount[c];
`endif
          default:       ;
        endcase
      end
    end
    if (region == REGION_OVERFLOW) begin
      rdMux[NUM_CH-1:0] = overflow;
      rdOverflow        = Sys_RdEn;
    end
  end

  // NOTE: the enable array is a handful of control registers, not a RAM, so
  // it is reset like any other flop to keep Irq quiet out of reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int c = 0; c < NUM_CH; c++) intEn[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wrIntEn[c]) intEn[c] <= Sys_WrData;
      end
    end
  end

  // A fresh overflow in the read cycle survives the clear.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) overflow <= '0;
    else       overflow <= (rdOverflow ? '0 : overflow) | ovHit;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Sys_RdData  <= '0;
      Sys_RdValid <= 1'b0;
      Irq         <= 1'b0;
    end else begin
      Sys_RdValid <= Sys_RdEn;
      if (Sys_RdEn) Sys_RdData <= rdMux;
      Irq <= |irqTerm;
    end
  end

endmodule

// File: tb/tb_event_status_bank.sv
// ---------------------------------------------------------------------------
// tb_event_status_bank
//   Directed bench for event_status_bank (NUM_CH=4, DATA_WIDTH=32,
//   CLEAR_MASK=0xFF, CNT_WIDTH=4). Read expectations go into a scoreboard
//   queue when the read is issued and are compared when Sys_RdValid shows up.
//   Counter steps are built when EVENT_STATUS_COUNTER_EN is defined.
// ---------------------------------------------------------------------------
module tb_event_status_bank;
  import event_status_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int AW     = addrWidth(NUM_CH);

  logic                 Clock;
  logic                 Reset;
  logic                 Sys_RdEn;
  logic                 Sys_WrEn;
  logic [AW-1:0]        Sys_Addr;
  logic [DW-1:0]        Sys_WrData;
  logic [DW-1:0]        Sys_RdData;
  logic                 Sys_RdValid;
  logic [NUM_CH*DW-1:0] IO_Event;
  logic                 Irq;

  typedef struct {
    string         tag;
    logic [DW-1:0] data;
  } expT;

  expT expQ[$];
  int  checks   = 0;
  int  failures = 0;

  event_status_bank #(
    .NUM_CH      (NUM_CH),
    .DATA_WIDTH  (DW),
    .RESET_VALUE (32'h0),
    .CLEAR_MASK  (32'h0000_00FF),
    .CNT_WIDTH   (4)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Sys_RdEn    (Sys_RdEn),
    .Sys_WrEn    (Sys_WrEn),
    .Sys_Addr    (Sys_Addr),
    .Sys_WrData  (Sys_WrData),
    .Sys_RdData  (Sys_RdData),
    .Sys_RdValid (Sys_RdValid),
    .IO_Event    (IO_Event),
    .Irq         (Irq)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_CH*DW-1:0] ev(input int ch, input logic [DW-1:0] v);
    logic [NUM_CH*DW-1:0] r;
    r = '0;
    r[ch*DW +: DW] = v;
    return r;
  endfunction

  // One bus cycle, entered and left on a falling edge. A read pushes its
  // expected data and checks that Sys_RdValid is up one cycle later.
  task automatic step(input logic rd, input int addr, input logic wr, input logic [DW-1:0] wdata,
                      input logic [NUM_CH*DW-1:0] evt, input logic [DW-1:0] exp, input string tag);
    Sys_RdEn   = rd;
    Sys_WrEn   = wr;
    Sys_Addr   = addr[AW-1:0];
    Sys_WrData = wdata;
    IO_Event   = evt;
    if (rd) expQ.push_back('{tag: tag, data: exp});
    @(negedge Clock);
    Sys_RdEn   = 1'b0;
    Sys_WrEn   = 1'b0;
    Sys_WrData = '0;
    IO_Event   = '0;
    if (rd) check({tag, "_valid"}, DW'(Sys_RdValid), 32'h1);
  endtask

  task automatic readReg(input int addr, input logic [DW-1:0] exp, input string tag);
    step(1'b1, addr, 1'b0, '0, '0, exp, tag);
  endtask

  task automatic pulse(input logic [NUM_CH*DW-1:0] evt);
    step(1'b0, 0, 1'b0, '0, evt, '0, "");
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, '0, '0, '0, "");
  endtask

  // Scoreboard consumer.
  always @(negedge Clock) begin
    expT e;
    if (!Reset && Sys_RdValid) begin
      checks++;
      assert (expQ.size() != 0) else begin
        failures++;
        $error("FAIL spurious_rdvalid observed=1 expected=0");
      end
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        check(e.tag, Sys_RdData, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset      = 1'b1;
    Sys_RdEn   = 1'b0;
    Sys_WrEn   = 1'b0;
    Sys_Addr   = '0;
    Sys_WrData = '0;
    IO_Event   = '0;
    repeat (2) @(negedge Clock);
    check("reset_rddata",  Sys_RdData,       32'h0);
    check("reset_rdvalid", DW'(Sys_RdValid), 32'h0);
    check("reset_irq",     DW'(Irq),         32'h0);
    Reset = 1'b0;
    @(negedge Clock);

    // Reset value and basic read-clear.
    readReg(0, 32'h0, "rd_reset_status0");
    check("irq_idle", DW'(Irq), 32'h0);
    pulse(ev(1, 32'h0000_0005));
    readReg(1, 32'h5, "rd_ch1_first");
    readReg(1, 32'h0, "rd_ch1_reread");

    // Clear mask keeps bits above 0xFF.
    pulse(ev(0, 32'h0000_0F0F));
    readReg(0, 32'h0F0F, "rd_ch0_mask");
    readReg(0, 32'h0F00, "rd_ch0_retained");
    readReg(0, 32'h0F00, "rd_ch0_retained2");

    // Set wins over clear; the new event is not in the returned data.
    pulse(ev(2, 32'h1));
    step(1'b1, 2, 1'b0, '0, ev(2, 32'h2), 32'h1, "rd_ch2_setclr");
    readReg(2, 32'h2, "rd_ch2_survivor");
    readReg(2, 32'h0, "rd_ch2_cleared");

    // Status writes and unmapped addresses.
    step(1'b0, 1, 1'b1, 32'hFFFF_FFFF, '0, '0, "");
    readReg(1, 32'h0, "rd_ch1_after_write");
    readReg(15, 32'h0, "rd_unmapped");

    // Overflow: second hit on a pending bit, then a new hit during the clear.
    pulse(ev(3, 32'h4));
    pulse(ev(3, 32'h4));
    readReg(8, 32'h8, "rd_overflow");
    step(1'b1, 8, 1'b0, '0, ev(3, 32'h4), 32'h0, "rd_overflow_clr_race");
    readReg(8, 32'h8, "rd_overflow_new_wins");
    readReg(8, 32'h0, "rd_overflow_cleared");

    // Interrupt enable and registered Irq timing.
    step(1'b0, 7, 1'b1, 32'h4, '0, '0, "");
    check("irq_not_yet", DW'(Irq), 32'h0);
    idle();
    check("irq_asserted", DW'(Irq), 32'h1);
    step(1'b1, 7, 1'b1, 32'hC, '0, 32'h4, "rd_inten_rw_old");
    readReg(7, 32'hC, "rd_inten_new");
    readReg(3, 32'h4, "rd_ch3_irq_src");
    check("irq_held_clear_cycle", DW'(Irq), 32'h1);
    idle();
    check("irq_dropped", DW'(Irq), 32'h0);

`ifdef EVENT_STATUS_COUNTER_EN
    // ch0 saw one event cycle (0x0F0F) so far.
    readReg(9, 32'h1, "rd_count0_initial");
    for (int i = 0; i < 20; i++) pulse(ev(0, 32'h1));
    readReg(9, 32'hF, "rd_count0_saturated");
    step(1'b1, 9, 1'b0, '0, ev(0, 32'h1), 32'hF, "rd_count0_event_cycle");
    readReg(9, 32'h1, "rd_count0_restart");
    readReg(9, 32'h0, "rd_count0_zero");
`else
    pulse(ev(0, 32'h1));
    readReg(9, 32'h0, "rd_count_absent0");
    readReg(12, 32'h0, "rd_count_absent3");
`endif

    // Reset in the middle of a read: Sys_RdValid must drop at once.
    Sys_RdEn = 1'b1;
    Sys_Addr = '0;
    @(posedge Clock);
    #1;
    Sys_RdEn = 1'b0;
    check("rdvalid_before_reset", DW'(Sys_RdValid), 32'h1);
    Reset = 1'b1;
    #1;
    check("rdvalid_async_reset", DW'(Sys_RdValid), 32'h0);
    check("rddata_async_reset",  Sys_RdData,       32'h0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    readReg(7, 32'h0, "rd_inten_after_reset");
    readReg(0, 32'h0, "rd_status_after_reset");
    readReg(8, 32'h0, "rd_overflow_after_reset");

    repeat (3) @(negedge Clock);
    check("scoreboard_drained", DW'(expQ.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/event_status_bank.md
Name: event_status_bank

Overview:
- Multi-channel successor to the single read-clear status register.
- NUM_CH status registers; I/O logic sets bits by event pulses; the processor clears them on read.
- Adds per-channel interrupt enables, an overflow (lost-event) summary and a registered interrupt output.
- Sits in the peripheral space behind the I/O access bus; single clock domain (event sources are already synchronised upstream).

Parameters:
- NUM_CH, 4, number of status channels (1..16).
- DATA_WIDTH, 32, bits per status register.
- RESET_VALUE, '0, reset value of every status register.
- CLEAR_MASK, '1, bits cleared on read (1 = clear, 0 = remain); shared by all channels.
- CNT_WIDTH, 16, event counter width (used only with the optional feature).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Sys_RdEn  input  1  read strobe, one cycle per access.
- Sys_WrEn  input  1  write strobe.
- Sys_Addr  input  ADDR_WIDTH  word address; ADDR_WIDTH = $clog2(3*NUM_CH+1), a localparam.
- Sys_WrData  input  DATA_WIDTH  write data.
- Sys_RdData  output  DATA_WIDTH  registered read data.
- Sys_RdValid  output  1  high one cycle after an accepted Sys_RdEn.
- IO_Event  input  NUM_CH*DATA_WIDTH  set pulses; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- Irq  output  1  registered interrupt request.

Behaviour:
- Clock and reset: one clock (Clock); Reset is asynchronous and active-high.
- Reset values: status = RESET_VALUE; IntEn = 0; Overflow = 0; Sys_RdData = 0; Sys_RdValid = 0; Irq = 0.
- Address map:
  - 0..NUM_CH-1: Status[c], read-clear.
  - NUM_CH..2*NUM_CH-1: IntEn[c], read/write.
  - 2*NUM_CH: Overflow, NUM_CH LSBs, one per channel, read-clear.
  - Unmapped read returns 0; unmapped or status writes are ignored.
- Read:
  - Sys_RdEn samples Sys_Addr at edge N.
  - Sys_RdData/Sys_RdValid are valid after edge N+1, i.e. 1-cycle latency.
  - The returned value is the pre-clear value (including any clear-mask-retained bits).
- Status update per cycle: Status_next = (Status & ~Clr) | Event.
  - Clr = CLEAR_MASK when channel c is read this cycle, else 0.
  - Set wins over clear: an event in the read cycle survives and is not in the returned data.
- Overflow[c] sets when (Event & Status & ~Clr) != 0, i.e. an event hits a still-pending bit.
  - A read of Overflow clears it (all bits).
  - A new overflow in the same cycle wins.
- Writes:
  - IntEn write loads Sys_WrData in full.
  - Simultaneous Sys_RdEn and Sys_WrEn: both performed; read returns the old value.
- Irq: registered OR over c of |(Status[c] & IntEn[c]); asserts one cycle after the causing state change.
- Reset mid-operation: pending read discarded, Sys_RdValid forced low immediately.

Optional Feature:
- Macro: EVENT_STATUS_COUNTER_EN.
- When defined:
  - Adds Count[c] at addresses 2*NUM_CH+1..3*NUM_CH.
  - Count[c] increments by 1 in any cycle where channel c's event vector is nonzero.
  - Saturates at 2^CNT_WIDTH-1 and is zero-extended on read.
  - Read clears it; an event in the read cycle makes the new value 1.
  - Reset value 0.
- When undefined: those addresses read 0; no counter flops exist; ADDR_WIDTH is unchanged.

Decomposition:
- Package event_status_pkg: address-offset function (StatusBase = 0, IntEnBase = NUM_CH, OverflowAddr = 2*NUM_CH, CountBase = 2*NUM_CH+1) and the ADDR_WIDTH helper.
- Sub-module event_status_channel, one instance per channel via generate. It holds:
  - the status register with set/clear logic;
  - the overflow detect;
  - the optional counter;
  - and outputs its status, overflow pulse and irq term.

Test Plan:
- Reset, then read addr 0 → Sys_RdData = RESET_VALUE (0x0) one cycle later, Sys_RdValid pulse; Irq = 0.
- IO_Event ch1 = 0x0000_0005, then read addr 1 → returns 0x5; a re-read returns 0x0.
- CLEAR_MASK = 0x0000_00FF, ch0 status 0x0000_0F0F; read → returns 0x0F0F; status is then 0x0F00.
- Event 0x2 on ch2 in the same cycle as reading ch2 (status 0x1) → read returns 0x1; status is then 0x2.
- Overflow and interrupt:
  - Event 0x4 on ch3 twice without a read → Overflow read returns 0x8, a second read returns 0.
  - Write IntEn[3] = 0x4 → Irq high one cycle later; reading ch3 drops Irq the cycle after the clear.
- With EVENT_STATUS_COUNTER_EN, CNT_WIDTH = 4:
  - 20 event cycles on ch0 → Count[0] reads 15.
  - Read in an event cycle → returns 15, next read returns 1.
